uart_word_bridge: RTL

UART_WORD_BRIDGE -- requirements
Module: uart_word_bridge

---
 rtl/uart_bridge_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 48 ++++
 rtl/uart_word_bridge.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared state encodings and constants for the UART word bridge.
package uart_bridge_pkg;

    localparam int unsigned BIT_CNT = 8;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_PAR   = 3'd3,
        R_STOP  = 3'd4
    } rx_state_e;

    typedef enum logic [2:0] {
        T_IDLE  = 3'd0,
        T_START = 3'd1,
        T_DATA  = 3'd2,
        T_PAR   = 3'd3,
        T_STOP  = 3'd4
    } tx_state_e;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: emits a one-cycle tick every CLK_PER_BIT cycles, or after
// half a period for the first tick following a restart with half selected.
module uart_baud_tick #(
    parameter int unsigned CLK_PER_BIT = 5200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic half,
    output logic tick
);

    localparam logic [15:0] FULL_LAST = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLK_PER_BIT / 2) - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        half_q, half_d;

    assign tick = (cnt_q == (half_q ? HALF_LAST : FULL_LAST));

    // Next counter value: hold at zero while restarting, wrap on every tick.
    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        if (restart) begin
            cnt_d  = 16'd0;
            half_d = half;
        end else if (tick) begin
            cnt_d  = 16'd0;
            half_d = 1'b0;
        end else begin
            cnt_d  = cnt_q + 16'd1;
            half_d = half_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 16'd0;
            half_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end

endmodule

// File: rtl/uart_word_bridge.sv
// UART <-> word bridge: assembles BYTES received bytes into a word and serialises
// words byte 0 first. Define UART_PARITY_EN for 8E1 framing (default 8N1).
module uart_word_bridge
    import uart_bridge_pkg::*;
#(
    parameter  int unsigned CLK_PER_BIT = 5200,
    parameter  int unsigned BYTES       = 4,
    localparam int unsigned DATA_W      = 8 * BYTES
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Rx,
    output logic              Tx,
    output logic [7:0]        RxData,
    output logic [DATA_W-1:0] word_out,
    output logic              word_out_valid,
    input  logic [DATA_W-1:0] in_32,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              frame_err,
    output logic              parity_err
);

`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    localparam logic [3:0] LAST_BYTE = 4'(BYTES - 1);
    localparam logic [2:0] LAST_BIT  = 3'(BIT_CNT - 1);

    // ---------------- receive path ----------------
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e         rx_state_q, rx_state_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [3:0]        rx_byte_q, rx_byte_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] word_acc_q, word_acc_d;
    logic              word_done_q, word_done_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic [DATA_W-1:0] word_out_q, word_out_d;
    logic              word_valid_q, word_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              rx_restart_s, rx_half_s, rx_tick_s;

    uart_baud_tick #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx_tick (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .restart (rx_restart_s),
        .half    (rx_half_s),
        .tick    (rx_tick_s)
    );

    // Receive FSM next state; the completed word is published one cycle after the last stop sample.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_bit_d     = rx_bit_q;
        rx_byte_d    = rx_byte_q;
        rx_shift_d   = rx_shift_q;
        word_acc_d   = word_acc_q;
        rx_data_d    = rx_data_q;
        word_done_d  = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        rx_restart_s = 1'b0;
        rx_half_s    = 1'b0;
        word_valid_d = word_done_q;
        if (word_done_q) begin
            word_out_d = word_acc_q;
        end else begin
            word_out_d = word_out_q;
        end
        case (rx_state_q)
            R_IDLE: begin
                rx_restart_s = 1'b1;
                rx_half_s    = 1'b1;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = R_START;
                end else begin
                    rx_state_d = R_IDLE;
                end
            end
            R_START: begin
                if (rx_tick_s) begin
                    if (rx_sync_q) begin
                        rx_state_d = R_IDLE;
                    end else begin
                        rx_state_d = R_DATA;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_state_d = R_START;
                end
            end
            R_DATA: begin
                if (rx_tick_s) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = PAR_EN ? R_PAR : R_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_state_d = R_DATA;
                end
            end
            R_PAR: begin
                if (rx_tick_s) begin
                    if (rx_sync_q != even_par(rx_shift_q)) begin
                        parity_err_d = 1'b1;
                        rx_byte_d    = 4'd0;
                        rx_state_d   = R_IDLE;
                    end else begin
                        rx_state_d = R_STOP;
                    end
                end else begin
                    rx_state_d = R_PAR;
                end
            end
            R_STOP: begin
                if (rx_tick_s) begin
                    rx_state_d = R_IDLE;
                    if (rx_sync_q) begin
                        rx_data_d = rx_shift_q;
                        for (int k = 0; k < BYTES; k++) begin
                            if (rx_byte_q == 4'(k)) begin
                                word_acc_d[8*k +: 8] = rx_shift_q;
                            end else begin
                                word_acc_d[8*k +: 8] = word_acc_q[8*k +: 8];
                            end
                        end
                        if (rx_byte_q == LAST_BYTE) begin
                            rx_byte_d   = 4'd0;
                            word_done_d = 1'b1;
                        end else begin
                            rx_byte_d = rx_byte_q + 4'd1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        rx_byte_d   = 4'd0;
                    end
                end else begin
                    rx_state_d = R_STOP;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // Receive registers, including the Rx synchronizer and edge-detect history.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= R_IDLE;
            rx_bit_q     <= 3'd0;
            rx_byte_q    <= 4'd0;
            rx_shift_q   <= 8'd0;
            word_acc_q   <= '0;
            word_done_q  <= 1'b0;
            rx_data_q    <= 8'd0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_meta_q    <= Rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_bit_q     <= rx_bit_d;
            rx_byte_q    <= rx_byte_d;
            rx_shift_q   <= rx_shift_d;
            word_acc_q   <= word_acc_d;
            word_done_q  <= word_done_d;
            rx_data_q    <= rx_data_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // ---------------- transmit path ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [3:0]        tx_byte_q, tx_byte_d;
    logic [DATA_W-1:0] tx_word_q, tx_word_d;
    logic              tx_q, tx_d;
    logic              in_ready_q, in_ready_d;
    logic              tx_restart_s, tx_tick_s;

    uart_baud_tick #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx_tick (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .restart (tx_restart_s),
        .half    (1'b0),
        .tick    (tx_tick_s)
    );

    // Transmit FSM; the word register shifts down a byte per frame so bit selection stays local.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_bit_d     = tx_bit_q;
        tx_byte_d    = tx_byte_q;
        tx_word_d    = tx_word_q;
        tx_restart_s = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                tx_restart_s = 1'b1;
                if (in_valid && in_ready_q) begin
                    tx_word_d  = in_32;
                    tx_byte_d  = 4'd0;
                    tx_state_d = T_START;
                end else begin
                    tx_state_d = T_IDLE;
                end
            end
            T_START: begin
                if (tx_tick_s) begin
                    tx_state_d = T_DATA;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_state_d = T_START;
                end
            end
            T_DATA: begin
                if (tx_tick_s) begin
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = PAR_EN ? T_PAR : T_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_state_d = T_DATA;
                end
            end
            T_PAR: begin
                if (tx_tick_s) begin
                    tx_state_d = T_STOP;
                end else begin
                    tx_state_d = T_PAR;
                end
            end
            T_STOP: begin
                if (tx_tick_s) begin
                    if (tx_byte_q == LAST_BYTE) begin
                        tx_state_d = T_IDLE;
                    end else begin
                        tx_byte_d  = tx_byte_q + 4'd1;
                        tx_word_d  = tx_word_q >> 4'd8;
                        tx_state_d = T_START;
                    end
                end else begin
                    tx_state_d = T_STOP;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase

        case (tx_state_d)
            T_START: tx_d = 1'b0;
            T_DATA:  tx_d = tx_word_d[tx_bit_d];
            T_PAR:   tx_d = even_par(tx_word_d[7:0]);
            T_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        in_ready_d = (tx_state_d == T_IDLE);
    end

    // Transmit registers; Tx and in_ready come straight from flops.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_state_q <= T_IDLE;
            tx_bit_q   <= 3'd0;
            tx_byte_q  <= 4'd0;
            tx_word_q  <= '0;
            tx_q       <= 1'b1;
            in_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_word_q  <= tx_word_d;
            tx_q       <= tx_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign Tx             = tx_q;
    assign in_ready       = in_ready_q;
    assign RxData         = rx_data_q;
    assign word_out       = word_out_q;
    assign word_out_valid = word_valid_q;
    assign frame_err      = frame_err_q;
    assign parity_err     = parity_err_q;

endmodule
